// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - shared fetch-stage types and constants
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch: PC register, imem handshake, stall buffer, redirect drop
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        StallF,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        FetchValid
);

  fetch_state_e state, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  buf_q, buf_d;
  logic [31:0]  tgt_q, tgt_d;
  logic [31:0]  pc_plus4;
  logic [31:0]  redirect_pc;

  assign pc_plus4    = pc_q + 32'd4;
  assign redirect_pc = word_align(RedirectPC);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      pc_q  <= RESET_PC;
      buf_q <= 32'd0;
      tgt_q <= 32'd0;
    end else begin
      state <= state_d;
      pc_q  <= pc_d;
      buf_q <= buf_d;
      tgt_q <= tgt_d;
    end
  end

  // Redirect outranks StallF everywhere; DROP keeps the request alive until the stale ack returns.
  always_comb begin
    state_d = state;
    pc_d    = pc_q;
    buf_d   = buf_q;
    tgt_d   = tgt_q;
    case (state)
      FETCH: begin
        if (Redirect) begin
          if (imem_ack) begin
            pc_d = redirect_pc;
          end else begin
            tgt_d   = redirect_pc;
            state_d = DROP;
          end
        end else if (imem_ack) begin
          if (StallF) begin
            buf_d   = imem_rdata;
            state_d = HOLD;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      HOLD: begin
        if (Redirect) begin
          pc_d    = redirect_pc;
          state_d = FETCH;
        end else if (!StallF) begin
          pc_d    = pc_plus4;
          state_d = FETCH;
        end
      end
      DROP: begin
        if (Redirect) begin
          tgt_d = redirect_pc;
          if (imem_ack) begin
            pc_d    = redirect_pc;
            state_d = FETCH;
          end
        end else if (imem_ack) begin
          pc_d    = tgt_q;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    imem_req   = 1'b0;
    FetchValid = 1'b0;
    InstrF     = NOP_INSTR;
    case (state)
      FETCH: begin
        imem_req   = 1'b1;
        FetchValid = imem_ack;
        InstrF     = imem_ack ? imem_rdata : NOP_INSTR;
      end
      HOLD: begin
        FetchValid = 1'b1;
        InstrF     = buf_q;
      end
      DROP: begin
        imem_req = 1'b1;
      end
      default: ;
    endcase
  end

  assign imem_addr = pc_q;
  assign PCF       = pc_q;
  assign PCPlus4F  = pc_plus4;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed and random checks of if_fetch_unit against a queue-based model
module tb_if_fetch_unit;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        StallF, Redirect, imem_ack;
  logic [31:0] RedirectPC, imem_rdata;
  logic        imem_req, FetchValid;
  logic [31:0] imem_addr, InstrF, PCF, PCPlus4F;

  int n_vec = 0;
  int n_err = 0;

  // Model: pc being fetched, a buffered instruction awaiting handoff, a target awaiting a stale ack.
  logic [31:0] m_pc;
  logic [31:0] m_held[$];
  logic [31:0] m_tgt[$];

  always #5 clock = ~clock;

  if_fetch_unit dut (
    .clock(clock), .reset(reset), .StallF(StallF), .Redirect(Redirect),
    .RedirectPC(RedirectPC), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .InstrF(InstrF), .PCF(PCF),
    .PCPlus4F(PCPlus4F), .FetchValid(FetchValid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC;
    m_held.delete();
    m_tgt.delete();
  endtask

  task automatic step(input logic stall, input logic redir, input logic [31:0] rpc,
                      input logic ack, input logic [31:0] rdata);
    logic [31:0] e_instr;
    logic [31:0] rpc_a;
    logic        e_valid;
    logic        e_req;
    @(negedge clock);
    StallF = stall; Redirect = redir; RedirectPC = rpc; imem_ack = ack; imem_rdata = rdata;
    #1;
    rpc_a = {rpc[31:2], 2'b00};
    e_req = (m_held.size() == 0);
    if (m_held.size() != 0) begin
      e_valid = 1'b1; e_instr = m_held[0];
    end else if (m_tgt.size() != 0) begin
      e_valid = 1'b0; e_instr = NOP;
    end else begin
      e_valid = ack;  e_instr = ack ? rdata : NOP;
    end
    check("imem_req", 32'(imem_req), 32'(e_req));
    if (e_req) check("imem_addr", imem_addr, m_pc);
    check("FetchValid", 32'(FetchValid), 32'(e_valid));
    check("InstrF", InstrF, e_instr);
    check("PCF", PCF, m_pc);
    check("PCPlus4F", PCPlus4F, m_pc + 32'd4);
    if (m_held.size() != 0) begin
      if (redir) begin m_held.delete(); m_pc = rpc_a; end
      else if (!stall) begin m_held.delete(); m_pc = m_pc + 32'd4; end
    end else if (m_tgt.size() != 0) begin
      if (redir) m_tgt[0] = rpc_a;
      if (ack) begin m_pc = m_tgt[0]; m_tgt.delete(); end
    end else begin
      if (redir) begin
        if (ack) m_pc = rpc_a;
        else m_tgt.push_back(rpc_a);
      end else if (ack) begin
        if (stall) m_held.push_back(rdata);
        else m_pc = m_pc + 32'd4;
      end
    end
  endtask

  initial begin
    reset = 1'b1; StallF = 1'b0; Redirect = 1'b0; RedirectPC = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    model_reset();
    repeat (2) @(negedge clock);
    #1;
    check("rst_PCF", PCF, RST_PC);
    check("rst_req", 32'(imem_req), 32'd1);
    check("rst_valid", 32'(FetchValid), 32'd0);
    check("rst_InstrF", InstrF, NOP);
    reset = 1'b0;

    // Zero-wait memory: one instruction per cycle.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, '0, 1'b1, $urandom);
      check("t1_addr", imem_addr, 32'(i * 4));
      check("t1_valid", 32'(FetchValid), 32'd1);
    end

    // Three wait states at 0x10.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, '0, 1'b0, $urandom);
      check("t2_addr", imem_addr, 32'h10);
      check("t2_instr", InstrF, NOP);
    end
    step(1'b0, 1'b0, '0, 1'b1, 32'h1234_5678);
    check("t2_ackdata", InstrF, 32'h1234_5678);

    // Arrival under stall goes to HOLD.
    step(1'b1, 1'b0, '0, 1'b1, 32'h00A0_0093);
    step(1'b1, 1'b0, '0, 1'b0, '0);
    check("t3_req", 32'(imem_req), 32'd0);
    check("t3_instr", InstrF, 32'h00A0_0093);
    step(1'b0, 1'b0, '0, 1'b0, '0);
    step(1'b0, 1'b0, '0, 1'b1, $urandom);
    check("t3_next", imem_addr, 32'h18);
    step(1'b0, 1'b0, '0, 1'b1, $urandom);

    // Redirect while 0x20 is in flight; stale data must be swallowed.
    step(1'b0, 1'b1, 32'h100, 1'b0, '0);
    check("t4_addr", imem_addr, 32'h20);
    step(1'b0, 1'b0, '0, 1'b0, '0);
    check("t4_hold_addr", imem_addr, 32'h20);
    step(1'b0, 1'b0, '0, 1'b1, 32'hDEAD_BEEF);
    check("t4_no_valid", 32'(FetchValid), 32'd0);
    step(1'b0, 1'b0, '0, 1'b0, '0);
    check("t4_target", imem_addr, 32'h100);

    // Redirect beats stall in HOLD; low target bits are dropped.
    step(1'b1, 1'b0, '0, 1'b1, $urandom);
    step(1'b1, 1'b1, 32'h40, 1'b0, '0);
    step(1'b0, 1'b0, '0, 1'b0, '0);
    check("t5_addr", imem_addr, 32'h40);
    step(1'b1, 1'b0, '0, 1'b1, $urandom);
    step(1'b1, 1'b1, 32'h103, 1'b0, '0);
    step(1'b0, 1'b0, '0, 1'b0, '0);
    check("t5_align", PCF, 32'h100);

    // Asynchronous reset while dropping.
    step(1'b0, 1'b1, 32'h200, 1'b0, '0);
    @(posedge clock);
    #2;
    Redirect = 1'b0; imem_ack = 1'b0;
    reset = 1'b1;
    #1;
    check("t6_PCF", PCF, RST_PC);
    check("t6_valid", 32'(FetchValid), 32'd0);
    check("t6_req", 32'(imem_req), 32'd1);
    check("t6_tgt", dut.tgt_q, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();

    for (int i = 0; i < 2000; i++) begin
      step(($urandom % 10) < 3, ($urandom % 10) == 0, $urandom, ($urandom % 2) == 1, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage of the 5-stage RISC-V pipeline. Drives the F-side inputs of the IF/ID register: InstrF, PCF, PCPlus4F.
- Owns the PC register and the request/acknowledge handshake to instruction memory.
- Buffers an instruction that arrives while decode is stalled.
- Handles branch/jump redirects, including cleanly discarding a memory response already in flight.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction presented when no valid fetch is available (addi x0,x0,0).

Ports:
- clock  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- StallF  in  1  hazard-unit stall; the IF/ID register is not capturing this cycle.
- Redirect  in  1  taken branch/jump from EX (PCSrcE).
- RedirectPC  in  32  redirect target (PCTargetE).
- imem_req  out  1  instruction-memory request.
- imem_addr  out  32  request address, word aligned.
- imem_ack  in  1  one-cycle pulse; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  instruction word.
- InstrF  out  32  instruction to IF/ID.
- PCF  out  32  PC of InstrF.
- PCPlus4F  out  32  PCF + 4, modulo 2^32.
- FetchValid  out  1  InstrF is a real fetched instruction, not NOP_INSTR.

Behaviour:
- Registers:
  - pc_q: reset value RESET_PC.
  - buf_q[31:0]: reset value 0.
  - tgt_q[31:0]: reset value 0.
  - state: reset value FETCH.
- Memory protocol:
  - While imem_req=1, imem_addr must not change until imem_ack.
  - At most one request is outstanding.
  - imem_ack may assert in the first cycle of a request (zero-wait memory).
  - imem_ack while imem_req=0 is ignored.
- States and outputs:
  - FETCH: imem_req=1, imem_addr=pc_q.
    - FetchValid=imem_ack; InstrF=imem_rdata when ack, else NOP_INSTR.
  - HOLD: imem_req=0, FetchValid=1, InstrF=buf_q.
  - DROP: imem_req=1, imem_addr=pc_q (old address), FetchValid=0, InstrF=NOP_INSTR.
  - In all states: PCF=pc_q and PCPlus4F=pc_q+4, both combinational.
- Transitions. Redirect has priority over StallF in every state.
  - FETCH, Redirect=1, ack=1: discard data; pc_q<=RedirectPC; stay FETCH.
  - FETCH, Redirect=1, ack=0: tgt_q<=RedirectPC; go DROP.
  - FETCH, ack=1, StallF=0: pc_q<=pc_q+4; stay FETCH. This gives 1 instruction/cycle with zero-wait memory.
  - FETCH, ack=1, StallF=1: buf_q<=imem_rdata; go HOLD.
  - FETCH, ack=0: hold pc_q; stay FETCH.
  - HOLD, Redirect=1: pc_q<=RedirectPC; go FETCH; buffer discarded.
  - HOLD, StallF=0: pc_q<=pc_q+4; go FETCH.
  - HOLD, StallF=1: stay HOLD.
  - DROP, Redirect=1: tgt_q<=RedirectPC (newest target wins). If ack=1 in the same cycle, pc_q<=RedirectPC and go FETCH.
  - DROP, ack=1, Redirect=0: pc_q<=tgt_q; go FETCH. The response data is never presented.
  - DROP, ack=0: stay DROP. StallF is ignored.
- pc_q advances only on handoff: FetchValid=1 and StallF=0 and Redirect=0.
- No bubble is generated by this block beyond NOP_INSTR. IF/ID flush remains the hazard unit's responsibility.
- RedirectPC[1:0] is ignored: pc_q captures {RedirectPC[31:2],2'b00}.
- pc_q+4 wraps from 32'hFFFF_FFFC to 32'h0000_0000.
- Reset mid-request: state returns to FETCH with pc_q=RESET_PC. The memory is required to drop any pending request on the same reset.

Decomposition:
- Shared pipeline package holds:
  - fetch state encoding: FETCH=2'd0, HOLD=2'd1, DROP=2'd2.
  - NOP_INSTR constant.
  - default RESET_PC.
- Single module, no sub-module. The next-PC mux and the state machine together are about 150–200 lines.

Test Plan:
1. Reset, zero-wait memory: reset released with RESET_PC=0 and imem_ack tied to imem_req → imem_addr 0,4,8,C on consecutive cycles, FetchValid=1 each cycle, PCPlus4F=PCF+4.
2. Wait states: ack arrives 3 cycles after req at addr 0x10 → imem_addr stays 0x10 for 3 cycles; InstrF=0x00000013, FetchValid=0 until the ack cycle; then InstrF=rdata, next address 0x14.
3. Stall on arrival: ack with rdata=0x00A00093 while StallF=1 for 2 cycles → HOLD, imem_req=0, InstrF=0x00A00093 held; on StallF=0 the next imem_addr is PC+4.
4. Redirect in flight: request at 0x20 outstanding, Redirect=1 with RedirectPC=0x100, ack 2 cycles later with rdata=0xDEADBEEF → 0xDEADBEEF never appears on InstrF with FetchValid=1; next request is at 0x100.
5. Simultaneous events: Redirect=1 (RedirectPC=0x40) and StallF=1 while in HOLD → next state FETCH at 0x40, buffer discarded. Second case: RedirectPC=0x103 → PCF=0x100.
6. Reset mid-DROP: assert reset while in DROP → immediately state FETCH, PCF=RESET_PC, FetchValid=0; tgt_q cleared to 0.
